// File: rtl/tracker_pkg.sv
// Shared definitions for the mask bounding-box tracker and its neighbours.
// Holds the default frame geometry, the coordinate width, the tracker FSM state encoding,
// and the packed bounding-box record that the overlay block also consumes.
package tracker_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COORD_W      = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REPORT
  } state_t;

  typedef struct packed {
    coord_t x_min;
    coord_t x_max;
    coord_t y_min;
    coord_t y_max;
  } bbox_t;

  // Degenerate box covering a single pixel; seeds the bounds on the first foreground hit.
  function automatic bbox_t bbox_point(input coord_t x, input coord_t y);
    bbox_t b;
    b.x_min = x;
    b.x_max = x;
    b.y_min = y;
    b.y_max = y;
    return b;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster position counter for a frame of H_ACTIVE x V_ACTIVE pixels.
// Ports:
//   clk, reset (async, active-low)
//   start   : current word is pixel (0,0); the next word will be (1,0)
//   advance : current word consumed; step to the next raster position
//   x, y    : raster position of the word currently presented
//   last    : position is the final pixel of the frame
module raster_counter
  import tracker_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   advance,
  output coord_t x,
  output coord_t y,
  output logic   last
);

  localparam coord_t X_LAST = coord_t'(H_ACTIVE - 1);
  localparam coord_t Y_LAST = coord_t'(V_ACTIVE - 1);

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (start) begin
      x <= coord_t'(1);
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + coord_t'(1);
      end else begin
        x <= x + coord_t'(1);
      end
    end
  end

  assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/mask_bbox_tracker.sv
// Reads the binary-mask frame buffer and reports, once per complete frame, the bounding
// box of foreground pixels, the foreground pixel count and an object-present flag.
// Ports:
//   clk, reset (async, active-low)
//   rd_data[15:0], rd_valid, rd_ready, sof : mask word stream, low byte nonzero = foreground
//   bbox_valid, bbox_ready                  : result handshake, held until accepted
//   x_min, x_max, y_min, y_max              : foreground bounds (0 when frame is empty)
//   pix_count                               : saturating foreground count
//   obj_found                               : pix_count >= MIN_PIXELS
//   frame_err                               : one-cycle pulse when sof aborts a frame
module mask_bbox_tracker
  import tracker_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int MIN_PIXELS = 64,
  parameter int CW         = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        rd_data,
  input  logic               rd_valid,
  output logic               rd_ready,
  input  logic               sof,
  output logic               bbox_valid,
  input  logic               bbox_ready,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic [CW-1:0]      pix_count,
  output logic               obj_found,
  output logic               frame_err
);

  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t        state_q, next_state;
  logic          rd_ready_q;
  logic          xfer, fg, start, advance, last, last_xfer;
  coord_t        x, y, pix_x, pix_y;

  bbox_t         acc_bbox, base_bbox, nxt_bbox;
  logic [CW-1:0] acc_cnt, base_cnt, nxt_cnt;
  logic          acc_any, base_any, nxt_any;

  // The high byte of a frame-buffer word carries no mask information.
  logic          unused_high_byte;
  assign unused_high_byte = |rd_data[15:8];

  assign rd_ready  = rd_ready_q;
  assign xfer      = rd_valid & rd_ready_q;
  assign fg        = |rd_data[7:0];
  assign start     = xfer & sof;
  assign advance   = xfer & ~sof & (state_q == ACCUM);
  assign last_xfer = advance & last;

  raster_counter #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .advance(advance),
    .x      (x),
    .y      (y),
    .last   (last)
  );

  // Next-state logic; rd_ready is registered from it so it is already 0 in the first
  // REPORT cycle and already 1 in the first IDLE cycle after the result is taken.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (last_xfer) next_state = REPORT;
      REPORT:  if (bbox_valid && bbox_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Accumulator update for the word currently presented. An sof word is pixel (0,0) of a
  // fresh frame, so it starts from cleared accumulators regardless of what was collected.
  always_comb begin
    pix_x     = sof ? '0 : x;
    pix_y     = sof ? '0 : y;
    base_bbox = sof ? '0 : acc_bbox;
    base_cnt  = sof ? '0 : acc_cnt;
    base_any  = sof ? 1'b0 : acc_any;
    nxt_bbox  = base_bbox;
    nxt_cnt   = base_cnt;
    nxt_any   = base_any;
    if (fg) begin
      nxt_any = 1'b1;
      nxt_cnt = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CW'(1);
      if (!base_any) begin
        nxt_bbox = bbox_point(pix_x, pix_y);
      end else begin
        if (pix_x < base_bbox.x_min) nxt_bbox.x_min = pix_x;
        if (pix_x > base_bbox.x_max) nxt_bbox.x_max = pix_x;
        if (pix_y < base_bbox.y_min) nxt_bbox.y_min = pix_y;
        if (pix_y > base_bbox.y_max) nxt_bbox.y_max = pix_y;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_ready_q <= 1'b0;
      acc_bbox   <= '0;
      acc_cnt    <= '0;
      acc_any    <= 1'b0;
    end else begin
      state_q    <= next_state;
      rd_ready_q <= (next_state != REPORT);
      if (start || advance) begin
        acc_bbox <= nxt_bbox;
        acc_cnt  <= nxt_cnt;
        acc_any  <= nxt_any;
      end
    end
  end

  // Result registers load from the post-update accumulators so the last pixel counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bbox_valid <= 1'b0;
      frame_err  <= 1'b0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      pix_count  <= '0;
      obj_found  <= 1'b0;
    end else begin
      frame_err <= start & (state_q == ACCUM);
      if (last_xfer) begin
        bbox_valid <= 1'b1;
        x_min      <= nxt_bbox.x_min;
        x_max      <= nxt_bbox.x_max;
        y_min      <= nxt_bbox.y_min;
        y_max      <= nxt_bbox.y_max;
        pix_count  <= nxt_cnt;
        obj_found  <= (nxt_cnt >= MIN_CNT);
      end else if (bbox_valid && bbox_ready) begin
        bbox_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mask_bbox_tracker.sv
// Directed bench for mask_bbox_tracker on an 8x4 frame with MIN_PIXELS=2.
module tb_mask_bbox_tracker;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int N  = H * V;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   rd_data = '0;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic          sof = 1'b0;
  logic          bbox_valid;
  logic          bbox_ready = 1'b1;
  logic [9:0]    x_min, x_max, y_min, y_max;
  logic [CW-1:0] pix_count;
  logic          obj_found;
  logic          frame_err;

  int errors = 0;
  int checks = 0;
  int n_results = 0;
  int n_err_pulses = 0;

  logic [15:0] img [N];

  mask_bbox_tracker #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .MIN_PIXELS(2),
    .CW        (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .sof       (sof),
    .bbox_valid(bbox_valid),
    .bbox_ready(bbox_ready),
    .x_min     (x_min),
    .x_max     (x_max),
    .y_min     (y_min),
    .y_max     (y_max),
    .pix_count (pix_count),
    .obj_found (obj_found),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bbox_valid && bbox_ready) n_results++;
    if (frame_err) n_err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until it is transferred; called 1 time unit after an edge.
  task automatic send(input logic [15:0] d, input logic s);
    int n;
    n = 0;
    rd_data  = d;
    sof      = s;
    rd_valid = 1'b1;
    while (!rd_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed rd_ready=0 expected=1");
    end
    step();
    rd_valid = 1'b0;
    sof      = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < N; i++) img[i] = 16'h0000;
  endtask

  task automatic send_frame();
    for (int i = 0; i < N; i++) send(img[i], i == 0);
  endtask

  task automatic check_result(input string tag, input int xmn, input int xmx, input int ymn,
                              input int ymx, input int cnt, input logic obj);
    check({tag, "_valid"}, 32'(bbox_valid), 32'd1);
    check({tag, "_x_min"}, 32'(x_min), xmn);
    check({tag, "_x_max"}, 32'(x_max), xmx);
    check({tag, "_y_min"}, 32'(y_min), ymn);
    check({tag, "_y_max"}, 32'(y_max), ymx);
    check({tag, "_count"}, 32'(pix_count), cnt);
    check({tag, "_obj"}, 32'(obj_found), 32'(obj));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rd_ready", 32'(rd_ready), 0);
    check("rst_valid", 32'(bbox_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_bbox", {x_min[7:0], x_max[7:0], y_min[7:0], y_max[7:0]}, 0);
    check("rst_count", 32'(pix_count), 0);
    check("rst_obj", 32'(obj_found), 0);
    @(negedge clk) reset = 1'b1;
    step();
    check("rst_release_rd_ready", 32'(rd_ready), 1);

    // 1: foreground square x=2..4, y=1..2
    clear_img();
    for (int yy = 1; yy <= 2; yy++)
      for (int xx = 2; xx <= 4; xx++) img[yy*H + xx] = 16'h00FF;
    send_frame();
    check_result("sq", 2, 4, 1, 2, 6, 1'b1);
    check("sq_rd_ready_report", 32'(rd_ready), 0);
    step();
    check("sq_valid_pulse", 32'(bbox_valid), 0);
    check("sq_idle_rd_ready", 32'(rd_ready), 1);
    check("sq_results", n_results, 1);

    // 2: empty frame
    clear_img();
    send_frame();
    check_result("empty", 0, 0, 0, 0, 0, 1'b0);
    step();
    check("empty_results", n_results, 2);

    // 3: high byte ignored, low byte 01 counts
    clear_img();
    img[0]       = 16'h0001;
    img[2*H + 5] = 16'hFF00;
    send_frame();
    check_result("hibyte", 0, 0, 0, 0, 1, 1'b0);
    step();
    check("hibyte_results", n_results, 3);

    // 4: backpressure, with foreground on the last pixel and count exactly MIN_PIXELS
    bbox_ready = 1'b0;
    clear_img();
    img[1]     = 16'h0080;
    img[N - 1] = 16'h00FF;
    send_frame();
    rd_data  = 16'h00FF;
    sof      = 1'b1;
    rd_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 32'(bbox_valid), 1);
      check("bp_rd_ready", 32'(rd_ready), 0);
      check("bp_bbox", {x_min[7:0], x_max[7:0], y_min[7:0], y_max[7:0]}, 32'h01070003);
      step();
    end
    rd_valid = 1'b0;
    sof      = 1'b0;
    check_result("bp", 1, 7, 0, 3, 2, 1'b1);
    bbox_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(bbox_valid), 0);
    check("bp_release_rd_ready", 32'(rd_ready), 1);
    check("bp_results", n_results, 4);
    check("bp_no_err", n_err_pulses, 0);

    // 5: early sof at word 13; aborted frame has foreground at words 1 and 8
    for (int i = 0; i < 13 + N; i++) begin
      int j;
      logic [15:0] w;
      j = i - 13;
      if (i < 13) w = (i == 1 || i == 8) ? 16'h00FF : 16'h0000;
      else        w = (j == 5 || j == 26) ? 16'h00FF : 16'h0000;
      send(w, i == 0 || i == 13);
      if (i == 13) check("early_err_pulse", 32'(frame_err), 1);
      if (i == 14) check("early_err_clear", 32'(frame_err), 0);
      if (i == 31) check("early_no_old_result", 32'(bbox_valid), 0);
    end
    check_result("early", 2, 5, 0, 3, 2, 1'b1);
    step();
    check("early_results", n_results, 5);
    check("early_err_count", n_err_pulses, 1);

    // 6a: reset while in REPORT
    bbox_ready = 1'b0;
    clear_img();
    img[9] = 16'h00FF;
    send_frame();
    check_result("pre_rst", 1, 1, 1, 1, 1, 1'b0);
    reset = 1'b0;
    #1;
    check("rpt_rst_valid", 32'(bbox_valid), 0);
    check("rpt_rst_bbox", {x_min[7:0], x_max[7:0], y_min[7:0], y_max[7:0]}, 0);
    check("rpt_rst_count", 32'(pix_count), 0);
    check("rpt_rst_rd_ready", 32'(rd_ready), 0);
    @(negedge clk) reset = 1'b1;
    step();
    check("rpt_rst_release", 32'(rd_ready), 1);

    // 6b: reset mid-ACCUM, stray non-sof words dropped, then a clean frame
    bbox_ready = 1'b1;
    clear_img();
    img[2] = 16'h00FF;
    for (int i = 0; i < 10; i++) send(img[i], i == 0);
    reset = 1'b0;
    #1;
    check("acc_rst_valid", 32'(bbox_valid), 0);
    check("acc_rst_rd_ready", 32'(rd_ready), 0);
    @(negedge clk) reset = 1'b1;
    step();
    check("acc_rst_release", 32'(rd_ready), 1);
    for (int i = 0; i < 3; i++) send(16'h00FF, 1'b0);
    clear_img();
    img[N - 1] = 16'h00FF;
    send_frame();
    check_result("clean", 7, 7, 3, 3, 1, 1'b0);
    step();
    check("clean_results", n_results, 6);
    check("clean_err_count", n_err_pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
